fifo_wr_arbiter: RTL

- Round-robin write-port arbiter that shares the single write port of fifo_single_clk (8-bit, depth 64) among NREQ producers.
- Grants one producer at a time for a bounded burst and drives the FIFO's wr_en/buf_in.
- Honours buf_full so no write is ever issued into a full FIFO.
- Sits between producer blocks and the FIFO; the read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write-port arbiter
//
// Purpose : arbiter FSM state type and the default geometry of the
//           fifo_single_clk instance this arbiter feeds.
// Ports   : none (package).
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int FIFO_DW    = 8;
  localparam int FIFO_DEPTH = 64;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting after the current owner
//
// Purpose : find the first set request bit at or after (owner+1) mod NREQ,
//           wrapping, so the current owner is always the last candidate.
// Ports   : req        in  NREQ    request vector
//           owner      in  OW      current / last grantee
//           valid      out 1       at least one request is set
//           next_owner out OW      index of the winning requester
module rr_pick #(
  parameter int NREQ = 4,
  parameter int OW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   owner,
  output logic            valid,
  output logic [OW-1:0]   next_owner
);

  always_comb begin
    valid      = 1'b0;
    next_owner = '0;
    // Offsets 1..NREQ: offset NREQ lands back on owner, giving it lowest priority.
    for (int i = 1; i <= NREQ; i++) begin
      if (!valid && req[(int'(owner) + i) % NREQ]) begin
        valid      = 1'b1;
        next_owner = OW'((int'(owner) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a single FIFO write port
//
// Purpose : shares the write port of fifo_single_clk among NREQ producers.
//           One producer owns the port for up to MAX_BURST accepted writes;
//           every grant change costs one idle cycle.  Data is passed through
//           combinationally, nothing is registered on the data path.
// Ports   : clk           in  1        rising-edge clock
//           rst           in  1        asynchronous active-high reset
//           req           in  NREQ     per-producer request, held with data until acked
//           data_in       in  NREQ*DW  producer i at [i*DW +: DW]
//           ack           out NREQ     one-hot, word written at this edge
//           fifo_wr_en    out 1        FIFO wr_en
//           fifo_buf_in   out DW       FIFO buf_in
//           fifo_buf_full in  1        FIFO buf_full
//           owner         out clog2    current or last grantee
//           busy          out 1        a burst is in progress
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = FIFO_DW,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       data_in,
  output logic [NREQ-1:0]          ack,
  output logic                     fifo_wr_en,
  output logic [DW-1:0]            fifo_buf_in,
  input  logic                     fifo_buf_full,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e      state;
  logic [CW-1:0]   burst_cnt;
  logic            pick_valid;
  logic [OW-1:0]   pick_owner;
  logic            owner_req;
  logic            accept;

  rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_rr_pick (
    .req        (req),
    .owner      (owner),
    .valid      (pick_valid),
    .next_owner (pick_owner)
  );

  // Everything below is derived from the registered state, so an async reset
  // removes ack/wr_en immediately without waiting for a clock edge.
  assign owner_req = req[owner];
  assign accept    = (state == BURST) && owner_req && !fifo_buf_full;
  assign busy      = (state == BURST);

  always_comb begin
    ack = '0;
    if (accept) ack[owner] = 1'b1;
  end

  assign fifo_wr_en  = accept;
  assign fifo_buf_in = accept ? data_in[int'(owner)*DW +: DW] : '0;

  // owner resets to NREQ-1 so the first search begins at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OW'(NREQ - 1);
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (pick_valid) begin
            owner <= pick_owner;
            state <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_cnt == CW'(MAX_BURST - 1)) state <= IDLE;
          end else if (!owner_req) begin
            state <= IDLE;
          end
          // Full with req still held: keep ownership and count, retry next cycle.
        end
      endcase
    end
  end

endmodule
